// File: rtl/resizer_pkg.sv
// Shared types and defaults for the resizer normalization stage.
package resizer_pkg;

  localparam int unsigned IMG_DIM    = 224;
  localparam int unsigned ZERO_POINT = 128;
  localparam int unsigned FIFO_DEPTH = 1024;

  typedef struct packed {
    logic signed [7:0] r, g, b;
  } norm_pixel_t;

  typedef struct packed {
    norm_pixel_t px;
    logic        first, lastInRow, last;
  } tagged_pixel_t;

  // Subtract the zero point in 9 bits and keep the low 8 as a signed int8.
  function automatic logic [7:0] normalize(input logic [7:0] c, input logic [7:0] zp);
    logic [8:0] d;
    d = {1'b0, c} - {1'b0, zp};
    return d[7:0];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with combinational read data, occupancy level and flush.
module pixel_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_addr;

  // A write in the flush cycle lands at slot 0 of the emptied buffer.
  always_comb begin
    wr_addr  = flush ? '0 : wr_ptr_q[AW-1:0];
    wr_ptr_d = flush ? '0 : wr_ptr_q;
    rd_ptr_d = flush ? '0 : rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_d + PW'(1);
    end
    if (rd_en && !flush) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/resizer_normalizer.sv
// Normalizes resizer RGB888 pixels to int8, tags frame position and buffers
// them behind a valid/ready output register.
module resizer_normalizer
  import resizer_pkg::*;
#(
  parameter int unsigned IMG_DIM    = resizer_pkg::IMG_DIM,
  parameter int unsigned FIFO_DEPTH = resizer_pkg::FIFO_DEPTH,
  parameter int unsigned ZERO_POINT = resizer_pkg::ZERO_POINT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          startNewImage,
  input  logic [7:0]                    inRed,
  input  logic [7:0]                    inGreen,
  input  logic [7:0]                    inBlue,
  input  logic                          inPixelValid,
  input  logic                          inEndOfImage,
  output logic [23:0]                   outPixel,
  output logic                          outValid,
  input  logic                          outReady,
  output logic                          outFirst,
  output logic                          outLastInRow,
  output logic                          outLast,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          overflow,
  output logic                          shortFrame,
  output logic                          frameDone
);

  localparam int unsigned CW   = $clog2(IMG_DIM);
  localparam int unsigned NPIX = IMG_DIM * IMG_DIM;
  localparam int unsigned PCW  = $clog2(NPIX + 1);
  localparam int unsigned TW   = $bits(tagged_pixel_t);

  logic [CW-1:0]  wx_q, wx_d, wy_q, wy_d, wx_base, wy_base;
  logic [PCW-1:0] cnt_q, cnt_d, cnt_base;
  logic           overflow_q, overflow_d;
  logic           short_q, short_d;
  logic           eoi_q, eoi_d;
  logic           out_valid_q, out_valid_d;
  logic           frame_done_q, frame_done_d;
  tagged_pixel_t  out_data_q, out_data_d;
  tagged_pixel_t  in_word;
  tagged_pixel_t  fifo_rd_data;
  logic           fifo_full, fifo_empty;
  logic           accept, drop, frame_full, eoi_rise, consume, load;

  pixel_fifo #(
    .WIDTH (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (startNewImage),
    .wr_en   (accept),
    .wr_data (in_word),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifoLevel)
  );

  // Write side: a new-frame pulse clears state before this cycle's pixel is judged.
  always_comb begin
    wx_base  = startNewImage ? '0 : wx_q;
    wy_base  = startNewImage ? '0 : wy_q;
    cnt_base = startNewImage ? '0 : cnt_q;

    frame_full = (cnt_base == PCW'(NPIX));
    accept     = inPixelValid && !frame_full && (startNewImage || !fifo_full);
    drop       = inPixelValid && !accept;
    eoi_rise   = inEndOfImage && !eoi_q;

    in_word.px.r      = normalize(inRed,   8'(ZERO_POINT));
    in_word.px.g      = normalize(inGreen, 8'(ZERO_POINT));
    in_word.px.b      = normalize(inBlue,  8'(ZERO_POINT));
    in_word.first     = (wx_base == '0) && (wy_base == '0);
    in_word.lastInRow = (wx_base == CW'(IMG_DIM - 1));
    in_word.last      = in_word.lastInRow && (wy_base == CW'(IMG_DIM - 1));

    wx_d  = wx_base;
    wy_d  = wy_base;
    cnt_d = cnt_base;
    if (accept) begin
      cnt_d = cnt_base + PCW'(1);
      if (in_word.lastInRow) begin
        wx_d = '0;
        wy_d = (wy_base == CW'(IMG_DIM - 1)) ? '0 : wy_base + CW'(1);
      end else begin
        wx_d = wx_base + CW'(1);
      end
    end

    overflow_d = (startNewImage ? 1'b0 : overflow_q) | drop;
    short_d    = (startNewImage ? 1'b0 : short_q) | (eoi_rise && (cnt_base < PCW'(NPIX)));
    eoi_d      = inEndOfImage;
  end

  // Read side: refill the output register whenever it is empty or handing off.
  always_comb begin
    consume      = out_valid_q && outReady;
    load         = !fifo_empty && !startNewImage && (!out_valid_q || consume);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = consume && out_data_q.last;
    if (startNewImage) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rd_data;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wx_q         <= '0;
      wy_q         <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      short_q      <= 1'b0;
      eoi_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      short_q      <= short_d;
      eoi_q        <= eoi_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign outPixel     = out_data_q.px;
  assign outFirst     = out_data_q.first;
  assign outLastInRow = out_data_q.lastInRow;
  assign outLast      = out_data_q.last;
  assign outValid     = out_valid_q;
  assign overflow     = overflow_q;
  assign shortFrame   = short_q;
  assign frameDone    = frame_done_q;

endmodule

// File: tb/tb_resizer_normalizer.sv
// Scoreboard bench for resizer_normalizer: expected words queued at drive time,
// popped on each output handshake.
module tb_resizer_normalizer;
  import resizer_pkg::*;

  localparam int unsigned NPIX = IMG_DIM * IMG_DIM;

  logic        clock = 1'b0;
  logic        reset;
  logic        startNewImage;
  logic [7:0]  inRed, inGreen, inBlue;
  logic        inPixelValid;
  logic        inEndOfImage;
  logic [23:0] outPixel;
  logic        outValid;
  logic        outReady;
  logic        outFirst, outLastInRow, outLast;
  logic [$clog2(FIFO_DEPTH):0] fifoLevel;
  logic        overflow, shortFrame, frameDone;

  resizer_normalizer dut (
    .clock         (clock),
    .reset         (reset),
    .startNewImage (startNewImage),
    .inRed         (inRed),
    .inGreen       (inGreen),
    .inBlue        (inBlue),
    .inPixelValid  (inPixelValid),
    .inEndOfImage  (inEndOfImage),
    .outPixel      (outPixel),
    .outValid      (outValid),
    .outReady      (outReady),
    .outFirst      (outFirst),
    .outLastInRow  (outLastInRow),
    .outLast       (outLast),
    .fifoLevel     (fifoLevel),
    .overflow      (overflow),
    .shortFrame    (shortFrame),
    .frameDone     (frameDone)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] model(input int idx, input logic [7:0] r, g, b);
    logic [7:0] zp;
    zp = 8'(ZERO_POINT);
    return {8'(r - zp), 8'(g - zp), 8'(b - zp),
            idx == 0, (idx % IMG_DIM) == IMG_DIM - 1, idx == NPIX - 1};
  endfunction

  // Output monitor: handshake scoreboard, stall stability and frameDone timing.
  logic        prev_stall = 1'b0;
  logic        prev_last_hs = 1'b0;
  logic [26:0] prev_word = '0;
  always @(negedge clock) begin
    logic [26:0] word;
    logic [26:0] e;
    if (reset) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      word = {outPixel, outFirst, outLastInRow, outLast};
      chk("frame_done", 32'(frameDone), 32'(prev_last_hs));
      if (frameDone) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 32'(outValid), 1);
        chk("stall_hold", 32'(word), 32'(prev_word));
      end
      if (outValid && outReady) begin
        chk("q_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_word", 32'(word), 32'(e));
        end
      end
      prev_stall   = outValid && !outReady && !startNewImage;
      prev_last_hs = outValid && outReady && outLast;
      prev_word    = word;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_px(input logic [7:0] r, g, b);
    inPixelValid = 1'b1;
    inRed   = r;
    inGreen = g;
    inBlue  = b;
  endtask

  task automatic new_frame();
    exp_q.delete();
    startNewImage = 1'b1;
    inPixelValid  = 1'b0;
    outReady      = 1'b0;
    step();
    startNewImage = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    inPixelValid = 1'b0;
    outReady     = 1'b1;
    while ((exp_q.size() != 0 || outValid) && k < 3000) begin
      step();
      k++;
    end
    step();
    chk({tag, "_q_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_valid"}, 32'(outValid), 0);
    chk({tag, "_level"}, 32'(fifoLevel), 0);
  endtask

  initial begin
    int n;
    int cyc;
    logic [7:0] r, g, b;

    reset = 1'b1;
    startNewImage = 1'b0;
    inRed = '0; inGreen = '0; inBlue = '0;
    inPixelValid = 1'b0;
    inEndOfImage = 1'b0;
    outReady = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(outValid), 0);
    chk("rst_pixel", 32'(outPixel), 0);
    chk("rst_tags", 32'({outFirst, outLastInRow, outLast}), 0);
    chk("rst_level", 32'(fifoLevel), 0);
    chk("rst_flags", 32'({overflow, shortFrame, frameDone}), 0);
    reset = 1'b0;
    step();

    // Full ramp frame at full throughput.
    outReady = 1'b1;
    for (int i = 0; i < int'(NPIX); i++) begin
      set_px(8'(i), 8'(i), 8'(i));
      exp_q.push_back(model(i, 8'(i), 8'(i), 8'(i)));
      step();
      if (i == 0) begin
        chk("lat_valid0", 32'(outValid), 0);
        chk("lat_level0", 32'(fifoLevel), 1);
      end
      if (i == 1) begin
        chk("lat_valid1", 32'(outValid), 1);
        chk("first_px", 32'(outPixel), 32'h808080);
        chk("first_tag", 32'(outFirst), 1);
      end
      if (i == 100) chk("level_steady", 32'(fifoLevel), 1);
    end
    chk("ramp_ovf", 32'(overflow), 0);
    set_px(8'd7, 8'd7, 8'd7);
    step();
    inPixelValid = 1'b0;
    step();
    chk("extra_px_ovf", 32'(overflow), 1);
    inEndOfImage = 1'b1;
    step();
    chk("full_no_short", 32'(shortFrame), 0);
    inEndOfImage = 1'b0;
    drain("ramp");
    chk("ramp_done_cnt", 32'(done_cnt), 1);

    // Channel extremes, with a new frame started on the same cycle as the pixel.
    exp_q.delete();
    startNewImage = 1'b1;
    set_px(8'd0, 8'd128, 8'd255);
    exp_q.push_back(model(0, 8'd0, 8'd128, 8'd255));
    outReady = 1'b1;
    step();
    startNewImage = 1'b0;
    inPixelValid  = 1'b0;
    step();
    chk("extreme_px", 32'(outPixel), 32'h80007F);
    chk("extreme_ovf_clr", 32'(overflow), 0);
    drain("extreme");

    // Consumer stalled long enough to overflow.
    new_frame();
    for (int i = 0; i < 1100; i++) begin
      set_px(8'(i), 8'(i), 8'(i));
      if (i < int'(FIFO_DEPTH) + 1) exp_q.push_back(model(i, 8'(i), 8'(i), 8'(i)));
      step();
    end
    inPixelValid = 1'b0;
    chk("ovf_level", 32'(fifoLevel), FIFO_DEPTH);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_out_valid", 32'(outValid), 1);
    chk("ovf_out_first", 32'(outFirst), 1);
    drain("ovf");

    // Random backpressure with a slower producer: nothing may drop.
    new_frame();
    n = 0;
    cyc = 0;
    while (n < 4000 && cyc < 20000) begin
      outReady = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) < 2) begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        set_px(r, g, b);
        exp_q.push_back(model(n, r, g, b));
        n++;
      end else begin
        inPixelValid = 1'b0;
      end
      step();
      cyc++;
    end
    chk("rand_sent", 32'(n), 4000);
    chk("rand_no_ovf", 32'(overflow), 0);
    drain("rand");

    // Mid-frame flush together with a valid pixel.
    new_frame();
    for (int i = 0; i < 3000; i++) begin
      set_px(8'(i), 8'(i + 1), 8'(i + 2));
      step();
    end
    chk("pre_flush_ovf", 32'(overflow), 1);
    exp_q.delete();
    startNewImage = 1'b1;
    set_px(8'd11, 8'd22, 8'd33);
    exp_q.push_back(model(0, 8'd11, 8'd22, 8'd33));
    step();
    startNewImage = 1'b0;
    inPixelValid  = 1'b0;
    chk("flush_valid", 32'(outValid), 0);
    chk("flush_ovf_clr", 32'(overflow), 0);
    chk("flush_level", 32'(fifoLevel), 1);
    outReady = 1'b1;
    step();
    chk("flush_next_valid", 32'(outValid), 1);
    chk("flush_next_first", 32'(outFirst), 1);
    drain("flush");

    // Short frame: end-of-image after 1000 pixels.
    new_frame();
    outReady = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      set_px(8'(i), 8'(i), 8'(i));
      exp_q.push_back(model(i, 8'(i), 8'(i), 8'(i)));
      step();
    end
    inPixelValid = 1'b0;
    chk("short_before", 32'(shortFrame), 0);
    inEndOfImage = 1'b1;
    step();
    chk("short_set", 32'(shortFrame), 1);
    drain("short");
    chk("short_no_done", 32'(done_cnt), 1);
    inEndOfImage = 1'b0;
    new_frame();
    chk("short_cleared", 32'(shortFrame), 0);

    // Asynchronous reset with data in flight.
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_px(8'(i), 8'(i), 8'(i));
      step();
    end
    inPixelValid = 1'b0;
    chk("pre_rst_valid", 32'(outValid), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(outValid), 0);
    chk("async_rst_level", 32'(fifoLevel), 0);
    chk("async_rst_pixel", 32'(outPixel), 0);
    exp_q.delete();
    #10 reset = 1'b0;
    step();
    chk("post_rst_valid", 32'(outValid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
